// File: rtl/pipe_ctrl_unit.sv
// Main control unit: decodes the ID opcode into a control bundle and carries it
// through the ID/EX and EX/MEM stages with hazard, redirect and freeze handling.
module pipe_ctrl_unit #(
  parameter int unsigned ALUW = 3,
  parameter int unsigned REGW = 3,
  parameter int unsigned LINK = 2**REGW-1,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [ALUW:0]   id_op,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic [REGW-1:0] id_rd,
  input  logic            ex_redirect,
  input  logic            mem_busy,
  output logic            stall,
  output logic            flush,
  output logic            ex_valid,
  output logic            ex_reg_dst,
  output logic            ex_write_en,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic            ex_mem_write,
  output logic            ex_mem_read,
  output logic            ex_mem_to_reg,
  output logic            ex_jump,
  output logic            ex_jal,
  output logic            ex_jr,
  output logic [ALUW-1:0] ex_aluop,
  output logic [REGW-1:0] ex_wr_addr,
  output logic            mem_valid,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_write_en,
  output logic            mem_to_reg,
  output logic            mem_jal,
  output logic [REGW-1:0] mem_wr_addr,
  output logic            illegal_seen,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    K_LW  = 3'd0,
    K_SW  = 3'd1,
    K_BEQ = 3'd2,
    K_JR  = 3'd3,
    K_J   = 3'd4,
    K_JAL = 3'd5
  } mem_op_e;

  typedef struct packed {
    logic            valid;
    logic            reg_dst;
    logic            write_en;
    logic            alu_src;
    logic            branch;
    logic            mem_write;
    logic            mem_read;
    logic            mem_to_reg;
    logic            jump;
    logic            jal;
    logic            jr;
    logic [ALUW-1:0] aluop;
    logic [REGW-1:0] wr_addr;
  } ctrl_t;

  typedef struct packed {
    logic            valid;
    logic            read;
    logic            write;
    logic            write_en;
    logic            to_reg;
    logic            jal;
    logic [REGW-1:0] wr_addr;
  } mem_ctrl_t;

  ctrl_t           dec;
  ctrl_t           ex_q;
  mem_ctrl_t       mem_q;
  logic [ALUW-1:0] k;
  logic            use_rs;
  logic            use_rt;
  logic            illegal;
  logic            load_use;

  always_comb begin
    dec     = '0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    illegal = 1'b0;
    k       = id_op[ALUW-1:0];
    if (!id_op[ALUW]) begin
      dec.valid    = 1'b1;
      dec.aluop    = k;
      dec.write_en = 1'b1;
      dec.wr_addr  = id_rd;
      use_rs       = 1'b1;
      use_rt       = 1'b1;
    end else begin
      dec.valid = 1'b1;
      case (k)
        ALUW'(K_LW): begin
          dec.mem_read   = 1'b1;
          dec.alu_src    = 1'b1;
          dec.write_en   = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.wr_addr    = id_rt;
          use_rs         = 1'b1;
        end
        ALUW'(K_SW): begin
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.reg_dst   = 1'b1;
          use_rs        = 1'b1;
          use_rt        = 1'b1;
        end
        ALUW'(K_BEQ): begin
          dec.branch  = 1'b1;
          dec.reg_dst = 1'b1;
          dec.aluop   = ALUW'(1);
          use_rs      = 1'b1;
          use_rt      = 1'b1;
        end
        ALUW'(K_JR): begin
          dec.jr = 1'b1;
          use_rs = 1'b1;
        end
        ALUW'(K_J): dec.jump = 1'b1;
        ALUW'(K_JAL): begin
          dec.jump     = 1'b1;
          dec.jal      = 1'b1;
          dec.write_en = 1'b1;
          dec.wr_addr  = REGW'(LINK);
        end
        default: begin
          dec     = '0;
          illegal = 1'b1;
        end
      endcase
    end
    if (dec.wr_addr == '0) dec.write_en = 1'b0;
    // An empty ID slot decodes to a bubble with no sources and no illegal flag.
    if (!id_valid) begin
      dec     = '0;
      use_rs  = 1'b0;
      use_rt  = 1'b0;
      illegal = 1'b0;
    end
  end

  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.wr_addr != '0) &&
               ((use_rs && (id_rs == ex_q.wr_addr)) ||
                (use_rt && (id_rt == ex_q.wr_addr)));
    stall    = !rst && (mem_busy || (!ex_redirect && load_use));
    flush    = !rst && !mem_busy && ex_redirect;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      mem_q        <= '0;
      illegal_seen <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else if (!mem_busy) begin
      mem_q.valid    <= ex_q.valid;
      mem_q.read     <= ex_q.mem_read;
      mem_q.write    <= ex_q.mem_write;
      mem_q.write_en <= ex_q.write_en;
      mem_q.to_reg   <= ex_q.mem_to_reg;
      mem_q.jal      <= ex_q.jal;
      mem_q.wr_addr  <= ex_q.wr_addr;
      ex_q           <= (ex_redirect || load_use) ? '0 : dec;
      if (illegal && !ex_redirect && !load_use) illegal_seen <= 1'b1;
      if (!ex_redirect && load_use && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNTW'(1);
      if (ex_redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_write_en   = ex_q.write_en;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_branch     = ex_q.branch;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_jump       = ex_q.jump;
  assign ex_jal        = ex_q.jal;
  assign ex_jr         = ex_q.jr;
  assign ex_aluop      = ex_q.aluop;
  assign ex_wr_addr    = ex_q.wr_addr;
  assign mem_valid     = mem_q.valid;
  assign mem_read      = mem_q.read;
  assign mem_write     = mem_q.write;
  assign mem_write_en  = mem_q.write_en;
  assign mem_to_reg    = mem_q.to_reg;
  assign mem_jal       = mem_q.jal;
  assign mem_wr_addr   = mem_q.wr_addr;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: an instruction-level model predicts every
// cycle's outputs; a monitor compares them against the DUT on the falling edge.
module tb_pipe_ctrl_unit;

  localparam int CMAX = 3;

  logic       clk = 1'b0;
  logic       rst, id_valid, ex_redirect, mem_busy;
  logic [3:0] id_op;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       stall, flush;
  logic       ex_valid, ex_reg_dst, ex_write_en, ex_alu_src, ex_branch, ex_mem_write;
  logic       ex_mem_read, ex_mem_to_reg, ex_jump, ex_jal, ex_jr;
  logic [2:0] ex_aluop, ex_wr_addr;
  logic       mem_valid, mem_read, mem_write, mem_write_en, mem_to_reg, mem_jal;
  logic [2:0] mem_wr_addr;
  logic       illegal_seen;
  logic [1:0] stall_cnt, flush_cnt;

  pipe_ctrl_unit #(.ALUW(3), .REGW(3), .LINK(7), .CNTW(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_write_en(ex_write_en),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_jump(ex_jump),
    .ex_jal(ex_jal), .ex_jr(ex_jr), .ex_aluop(ex_aluop), .ex_wr_addr(ex_wr_addr),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_en(mem_write_en), .mem_to_reg(mem_to_reg), .mem_jal(mem_jal),
    .mem_wr_addr(mem_wr_addr), .illegal_seen(illegal_seen),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [3:0] op;
    bit [2:0] rs, rt, rd;
  } ins_t;

  typedef struct {
    bit valid, reg_dst, we, alu_src, branch, mw, mr, mtr, jump, jal, jr;
    bit [2:0] aluop, wa;
  } ctl_t;

  typedef struct {
    bit [10:0] exf;
    bit [2:0]  exa, exw;
    bit [5:0]  mf;
    bit [2:0]  mw;
    bit        st, fl, il;
    bit [1:0]  sc, fc;
  } rec_t;

  rec_t exp_q[$];
  ins_t ex_ins, mem_ins;
  bit   m_ill;
  int   m_sc, m_fc;
  int   checks = 0;
  int   failures = 0;

  // Control bundle an instruction should carry, straight from the opcode table.
  function automatic ctl_t ctl_of(ins_t i);
    ctl_t c = '{default: 0};
    if (!i.v) return c;
    if (i.op < 8) begin
      c.aluop = i.op[2:0]; c.we = 1; c.wa = i.rd;
    end else begin
      case (i.op - 8)
        0: begin c.mr = 1; c.alu_src = 1; c.we = 1; c.mtr = 1; c.wa = i.rt; end
        1: begin c.mw = 1; c.alu_src = 1; c.reg_dst = 1; end
        2: begin c.branch = 1; c.reg_dst = 1; c.aluop = 1; end
        3: c.jr = 1;
        4: c.jump = 1;
        5: begin c.jump = 1; c.jal = 1; c.we = 1; c.wa = 7; end
        default: return c;
      endcase
    end
    c.valid = 1;
    if (c.wa == 0) c.we = 0;
    return c;
  endfunction

  function automatic void uses(bit [3:0] op, output bit ur, output bit ut);
    ur = 0; ut = 0;
    if (op < 8) begin ur = 1; ut = 1; end
    else if (op == 8 || op == 11) ur = 1;
    else if (op == 9 || op == 10) begin ur = 1; ut = 1; end
  endfunction

  task automatic cyc(input bit r, input bit v, input bit [3:0] op, input bit [2:0] rs,
                     input bit [2:0] rt, input bit [2:0] rd, input bit redir, input bit busy);
    rec_t e;
    ctl_t ce, cm;
    ins_t id;
    bit hz, ill, ur, ut;
    rst = r; id_valid = v; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    ex_redirect = redir; mem_busy = busy;
    ce = ctl_of(ex_ins);
    cm = ctl_of(mem_ins);
    e.exf = {ce.valid, ce.reg_dst, ce.we, ce.alu_src, ce.branch, ce.mw, ce.mr, ce.mtr,
             ce.jump, ce.jal, ce.jr};
    e.exa = ce.aluop;
    e.exw = ce.wa;
    e.mf  = {cm.valid, cm.mr, cm.mw, cm.we, cm.mtr, cm.jal};
    e.mw  = cm.wa;
    uses(op, ur, ut);
    hz  = ce.valid && ce.mr && ce.wa != 0 && v && ((ur && rs == ce.wa) || (ut && rt == ce.wa));
    ill = v && op >= 8 && (op - 8) > 5;
    e.st = !r && (busy || (!redir && hz));
    e.fl = !r && !busy && redir;
    e.il = m_ill;
    e.sc = 2'(m_sc);
    e.fc = 2'(m_fc);
    exp_q.push_back(e);
    if (r) begin
      ex_ins = '{default: 0}; mem_ins = '{default: 0};
      m_ill = 0; m_sc = 0; m_fc = 0;
    end else if (!busy) begin
      mem_ins = ex_ins;
      if (redir || hz) ex_ins = '{default: 0};
      else begin
        id.v = v; id.op = op; id.rs = rs; id.rt = rt; id.rd = rd;
        ex_ins = id;
      end
      if (ill && !redir && !hz) m_ill = 1;
      if (!redir && hz && m_sc < CMAX) m_sc++;
      if (redir && m_fc < CMAX) m_fc++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, 0, 0, 0, 0, 0);
  endtask

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endfunction

  initial begin : monitor
    rec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ex_flags", 32'({ex_valid, ex_reg_dst, ex_write_en, ex_alu_src, ex_branch,
                             ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_jump, ex_jal,
                             ex_jr}), 32'(e.exf));
        chk("ex_aluop", 32'(ex_aluop), 32'(e.exa));
        chk("ex_wr_addr", 32'(ex_wr_addr), 32'(e.exw));
        chk("mem_flags", 32'({mem_valid, mem_read, mem_write, mem_write_en, mem_to_reg,
                              mem_jal}), 32'(e.mf));
        chk("mem_wr_addr", 32'(mem_wr_addr), 32'(e.mw));
        chk("stall", 32'(stall), 32'(e.st));
        chk("flush", 32'(flush), 32'(e.fl));
        chk("illegal_seen", 32'(illegal_seen), 32'(e.il));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    ex_ins = '{default: 0}; mem_ins = '{default: 0};
    m_ill = 0; m_sc = 0; m_fc = 0;
    rst = 1; id_valid = 0; id_op = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    ex_redirect = 0; mem_busy = 0;
    @(posedge clk);
    #2;
    cyc(1, 0, 4'h0, 0, 0, 0, 0, 0);
    // ALU op 3 into rd=5
    cyc(0, 1, 4'h3, 1, 2, 5, 0, 0);
    idle(2);
    // LW rt=4 then dependent ALU held through the stall
    cyc(0, 1, 4'h8, 1, 4, 0, 0, 0);
    cyc(0, 1, 4'h2, 4, 1, 3, 0, 0);
    cyc(0, 1, 4'h2, 4, 1, 3, 0, 0);
    idle(1);
    // LW to r0 never stalls
    cyc(0, 1, 4'h8, 1, 0, 0, 0, 0);
    cyc(0, 1, 4'h2, 0, 0, 3, 0, 0);
    idle(1);
    // redirect while ALU op in ID
    cyc(0, 1, 4'h1, 2, 3, 6, 0, 0);
    cyc(0, 1, 4'h4, 1, 1, 2, 1, 0);
    idle(2);
    // busy freeze with redirect and hazard pending, then release
    cyc(0, 1, 4'h8, 2, 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 4'h0, 4, 4, 1, 1, 1);
    cyc(0, 1, 4'h0, 4, 4, 1, 1, 0);
    idle(2);
    // illegal opcode stays sticky
    cyc(0, 1, 4'hE, 1, 2, 3, 0, 0);
    idle(3);
    // JAL, J, JR, SW, BEQ
    cyc(0, 1, 4'hD, 0, 0, 0, 0, 0);
    cyc(0, 1, 4'hC, 0, 0, 0, 0, 0);
    cyc(0, 1, 4'hB, 3, 0, 0, 0, 0);
    cyc(0, 1, 4'h9, 1, 2, 0, 0, 0);
    cyc(0, 1, 4'hA, 1, 2, 0, 0, 0);
    idle(2);
    // seven load-use hazards saturate the 2-bit stall counter
    for (int i = 0; i < CMAX + 4; i++) begin
      cyc(0, 1, 4'h8, 1, 3, 0, 0, 0);
      cyc(0, 1, 4'h5, 2, 3, 4, 0, 0);
      cyc(0, 1, 4'h5, 2, 3, 4, 0, 0);
    end
    for (int i = 0; i < CMAX + 2; i++) cyc(0, 1, 4'h1, 1, 1, 1, 1, 0);
    // reset in the middle of a busy freeze
    cyc(0, 1, 4'h8, 1, 2, 0, 0, 0);
    cyc(0, 1, 4'h0, 2, 2, 2, 0, 1);
    cyc(1, 1, 4'h0, 2, 2, 2, 0, 1);
    idle(1);
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
          3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined, parametrised main control unit for the multi-stage datapath. Decodes the ID-stage opcode into the control bundle and registers it into the ID/EX and EX/MEM control stages. Detects load-use hazards, applies redirect flushes and memory-busy freezes, and flags illegal opcodes. Keeps saturating stall/flush performance counters.

## Interface
- ALUW, 3: ALU op width; opcode width is ALUW+1; must be ≥ 3.
- REGW, 3: register address width.
- LINK, 2**REGW-1: JAL link register index.
- CNTW, 16: performance counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_op  in  ALUW+1  opcode.
- id_rs, id_rt, id_rd  in  REGW each  register fields.
- ex_redirect  in  1  EX resolved a taken branch/jump; squash younger work.
- mem_busy  in  1  data memory not ready; freeze pipeline.
- stall  out  1  combinational; IF/ID must hold.
- flush  out  1  combinational; IF/ID must discard.
- ex_valid, ex_reg_dst, ex_write_en, ex_alu_src, ex_branch, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_jump, ex_jal, ex_jr  out  1 each  ID/EX control.
- ex_aluop  out  ALUW  ALU op.
- ex_wr_addr  out  REGW  destination register.
- mem_valid, mem_read, mem_write, mem_write_en, mem_to_reg, mem_jal  out  1 each  EX/MEM control.
- mem_wr_addr  out  REGW.
- illegal_seen  out  1  sticky illegal-opcode flag.
- stall_cnt, flush_cnt  out  CNTW each  saturating counters.

## Operation
- Opcode MSB=0: ALU op, aluop=id_op[ALUW-1:0], write_en=1, mem_to_reg=0, wr_addr=rd, sources rs,rt.
- Opcode MSB=1, offset k=id_op[ALUW-1:0]:
  - k=0 LW: mem_read, alu_src, write_en, mem_to_reg=1, aluop=ADD(0), wr_addr=rt, source rs.
  - k=1 SW: mem_write, alu_src, reg_dst, aluop=ADD, sources rs,rt.
  - k=2 BEQ: branch, reg_dst, aluop=SUB(1), sources rs,rt.
  - k=3 JR: jr, source rs.
  - k=4 J: jump.
  - k=5 JAL: jump, jal, write_en, wr_addr=LINK.
  - Other k: illegal. Decodes to bubble (all controls 0, valid=0) and sets illegal_seen on the edge it would enter EX.
- write_en is forced 0 whenever wr_addr=0.
- Load-use hazard: ex_valid && ex_mem_read && ex_wr_addr≠0 && id_valid && ex_wr_addr equals a used source of id_op. Result: stall=1, and a bubble (ex_valid=0, all ex_* controls 0) enters EX on the next edge.
- Priority, highest first: rst > mem_busy > ex_redirect > load-use.
  - mem_busy: all ex_* and mem_* registers hold; stall=1; flush=0; no counter increments. ex_redirect is ignored while busy; EX keeps asserting it.
  - ex_redirect (not busy): flush=1, stall=0; bubble into EX; EX contents still advance to MEM.
  - Load-use (not busy, no redirect): EX advances to MEM; bubble into EX.
  - Otherwise: decoded ID bundle enters EX (bubble if !id_valid); EX advances to MEM.
- stall_cnt increments on each load-use stall cycle. flush_cnt increments on each effective redirect cycle. Both saturate at 2**CNTW-1.

## Timing
- Reset: every ex_*, mem_*, illegal_seen, and counter = 0.
- stall and flush reflect current inputs and EX state combinationally. With rst=1 both are 0.
- Decode-to-EX latency 1 cycle; EX-to-MEM 1 cycle.
- Load-use stall lasts exactly one cycle; the dependent instruction enters EX on the following edge.
- Reset mid-stall or mid-busy clears all stages on that edge; no counter increment that cycle.

## Test plan
- Reset, then ALU op 0x3 with rd=5, id_valid=1 -> next cycle ex_valid=1, ex_aluop=3, ex_write_en=1, ex_wr_addr=5; one cycle later mem_write_en=1, mem_wr_addr=5.
- LW rt=4 followed by ALU op with rs=4 -> stall=1 for one cycle; EX bubble; ALU op enters EX next cycle; stall_cnt=1. Same sequence with rt=0 -> no stall.
- ex_redirect=1 while an ALU op is in ID -> flush=1; ex_valid=0 next cycle; flush_cnt=1; prior EX op appears in MEM.
- mem_busy=1 for 3 cycles with redirect and a hazard pending -> all stage outputs hold, stall=1, flush=0, counters unchanged; on release, redirect is taken first.
- Opcode 0xE (illegal for ALUW=3) -> ex_valid=0, all controls 0, illegal_seen=1 and stays set until rst.
- JAL -> ex_jump=ex_jal=ex_write_en=1, ex_wr_addr=7. Drive 2**CNTW+3 hazards with CNTW=2 -> stall_cnt stays at 3.
